cory_preset_seq: RTL and testbench

Upstream sequencer for `cory_counter`. It accepts a command {interval, repeat}, then drives the counter's preset port `repeat` times with `interval`. Between presets it waits for the counter's expiry valid. After each expiry it emits one indexed event, so a single command becomes a train of R timed ticks. It sits between a command source (CPU/register slice or another stage) and `cory_counter`, and consumes the counter's `o_z_*` output.

---
 rtl/cory_preset_seq_pkg.sv | 17 +
 rtl/cory_preset_seq_if.sv | 34 +++
 rtl/cory_queue.sv | 41 ++++
 rtl/cory_preset_seq.sv | 102 ++++++++++
 tb/tb_cory_preset_seq.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cory_preset_seq_pkg.sv
// Shared types and helpers for the cory_preset_seq sequencer.
package cory_preset_seq_pkg;

  // Sequencer FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_EMIT = 2'd3
  } st_e;

  // Width of the packed {last, index} event word for an M-bit index.
  function automatic int ev_width(input int m);
    return m + 1;
  endfunction

endpackage

// File: rtl/cory_preset_seq_if.sv
// Bundle of the sequencer's four handshake ports: command (a), preset to the
// counter (b), expiry from the counter (c) and indexed event out (z).
// The master modport is the sequencer's view; slave is its environment.
interface cory_preset_seq_if #(
  parameter int N = 8,
  parameter int M = 4
);
  logic         i_a_v;
  logic [N-1:0] i_a_interval;
  logic [M-1:0] i_a_repeat;
  logic         o_a_r;

  logic         o_b_v;
  logic [N-1:0] o_b_preset;
  logic         i_b_r;

  logic         i_c_v;
  logic         o_c_r;

  logic         o_z_v;
  logic [M-1:0] o_z_index;
  logic         o_z_last;
  logic         i_z_r;

  modport master (
    input  i_a_v, i_a_interval, i_a_repeat, i_b_r, i_c_v, i_z_r,
    output o_a_r, o_b_v, o_b_preset, o_c_r, o_z_v, o_z_index, o_z_last
  );

  modport slave (
    output i_a_v, i_a_interval, i_a_repeat, i_b_r, i_c_v, i_z_r,
    input  o_a_r, o_b_v, o_b_preset, o_c_r, o_z_v, o_z_index, o_z_last
  );
endinterface

// File: rtl/cory_queue.sv
// Optional single-entry output queue. Q==0 is a wire-through; any non-zero Q
// inserts one registered stage that still sustains one transfer per cycle.
module cory_queue #(
  parameter int N = 1,
  parameter int Q = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_v,
  input  logic [N-1:0] in_d,
  output logic         in_r,
  output logic         out_v,
  output logic [N-1:0] out_d,
  input  logic         out_r
);

  logic         full_q;
  logic [N-1:0] data_q;

  // Accept into the stage whenever it is empty or draining this cycle.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      // NOTE: the data word is reset too so the event port reads 0 after
      // reset; a single register costs nothing, unlike a deep storage array.
      data_q <= '0;
    end else if (in_v && in_r) begin
      full_q <= 1'b1;
      data_q <= in_d;
    end else if (out_r) begin
      full_q <= 1'b0;
    end
  end

  assign in_r  = (Q != 0) ? (!full_q || out_r) : out_r;
  assign out_v = (Q != 0) ? full_q : in_v;
  assign out_d = (Q != 0) ? data_q : in_d;

endmodule

// File: rtl/cory_preset_seq.sv
// Upstream sequencer for cory_counter: one {interval, repeat} command becomes
// R presets of the counter, each followed by an indexed event once it expires.
module cory_preset_seq
  import cory_preset_seq_pkg::*;
#(
  parameter int N  = 8,
  parameter int M  = 4,
  parameter int QZ = 0
) (
  input  logic               clk,
  input  logic               reset,
  cory_preset_seq_if.master  bus
);

  localparam int EW = ev_width(M);

  st_e          st, st_nxt;
  logic [N-1:0] interval_q;
  logic [M-1:0] repeat_q;
  logic [M-1:0] idx_q;

  logic          a_r, b_v, c_r, ev_v, ev_r;
  logic          a_fire, a_take, b_fire, c_fire, ev_fire;
  logic          last;
  logic [EW-1:0] ev_d, q_d;
  logic          q_v;

  // Handshake outputs decode from the state alone; reset forces them low.
  assign a_r  = (st == ST_IDLE) && !reset;
  assign b_v  = (st == ST_LOAD) && !reset;
  assign c_r  = (st == ST_WAIT) && !reset;
  assign ev_v = (st == ST_EMIT) && !reset;

  assign a_fire  = bus.i_a_v && a_r;
  // A zero-repeat command is consumed but starts nothing.
  assign a_take  = a_fire && (bus.i_a_repeat != '0);
  assign b_fire  = b_v && bus.i_b_r;
  assign c_fire  = bus.i_c_v && c_r;
  assign ev_fire = ev_v && ev_r;

  assign last = (idx_q == repeat_q - M'(1));
  assign ev_d = (st == ST_EMIT) ? {last, idx_q} : '0;

  assign bus.o_a_r      = a_r;
  assign bus.o_b_v      = b_v;
  assign bus.o_b_preset = (st == ST_LOAD) ? interval_q : '0;
  assign bus.o_c_r      = c_r;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) st <= ST_IDLE;
    else       st <= st_nxt;
  end

  // Next-state decode: IDLE -> LOAD -> WAIT -> EMIT -> (LOAD | IDLE).
  // NOTE: st_nxt is given a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE: if (a_take)  st_nxt = ST_LOAD;
      ST_LOAD: if (b_fire)  st_nxt = ST_WAIT;
      ST_WAIT: if (c_fire)  st_nxt = ST_EMIT;
      ST_EMIT: if (ev_fire) st_nxt = last ? ST_IDLE : ST_LOAD;
      default:              st_nxt = ST_IDLE;
    endcase
  end

  // Command latch and interval index; idx_q never wraps since R <= 2^M-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      interval_q <= '0;
      repeat_q   <= '0;
      idx_q      <= '0;
    end else if (a_take) begin
      interval_q <= bus.i_a_interval;
      repeat_q   <= bus.i_a_repeat;
      idx_q      <= '0;
    end else if (ev_fire && !last) begin
      idx_q <= idx_q + M'(1);
    end
  end

  // Event port, optionally decoupled by one registered stage.
  cory_queue #(
    .N (EW),
    .Q (QZ)
  ) u_ev_q (
    .clk   (clk),
    .reset (reset),
    .in_v  (ev_v),
    .in_d  (ev_d),
    .in_r  (ev_r),
    .out_v (q_v),
    .out_d (q_d),
    .out_r (bus.i_z_r)
  );

  assign bus.o_z_v                    = q_v && !reset;
  assign {bus.o_z_last, bus.o_z_index} = q_d;

endmodule

// File: tb/tb_cory_preset_seq.sv
// Directed bench for cory_preset_seq. Two instances (QZ=0 and QZ=1) share the
// stimulus, each paired with a small behavioural cory_counter; `sel` picks the
// instance whose handshakes are recorded and checked.
module tb_cory_preset_seq;

  localparam int N = 8;
  localparam int M = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         a_v    = 1'b0;
  logic [N-1:0] a_int  = '0;
  logic [M-1:0] a_rep  = '0;
  logic         b_r_en = 1'b1;
  logic         z_r    = 1'b1;

  int sel = 0;
  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  logic [1:0]   obs_a_r, obs_b_v, obs_b_r, obs_c_v, obs_c_r, obs_z_v, obs_z_last;
  logic [N-1:0] obs_preset [2];
  logic [M-1:0] obs_idx    [2];

  cory_preset_seq_if #(.N(N), .M(M)) bus [2] ();

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic         busy;
    logic         zv;
    logic [N-1:0] cnt;

    cory_preset_seq #(.N(N), .M(M), .QZ(g)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus[g])
    );

    assign bus[g].i_a_v        = a_v;
    assign bus[g].i_a_interval = a_int;
    assign bus[g].i_a_repeat   = a_rep;
    assign bus[g].i_b_r        = b_r_en && !busy && !zv;
    assign bus[g].i_c_v        = zv;
    assign bus[g].i_z_r        = z_r;

    assign obs_a_r[g]    = bus[g].o_a_r;
    assign obs_b_v[g]    = bus[g].o_b_v;
    assign obs_b_r[g]    = bus[g].i_b_r;
    assign obs_c_v[g]    = bus[g].i_c_v;
    assign obs_c_r[g]    = bus[g].o_c_r;
    assign obs_z_v[g]    = bus[g].o_z_v;
    assign obs_z_last[g] = bus[g].o_z_last;
    assign obs_preset[g] = bus[g].o_b_preset;
    assign obs_idx[g]    = bus[g].o_z_index;

    // Counter model: preset P accepted at edge A raises expiry after edge A+P.
    always @(posedge clk) begin
      if (reset) begin
        busy <= 1'b0;
        zv   <= 1'b0;
        cnt  <= '0;
      end else begin
        if (zv && bus[g].o_c_r) zv <= 1'b0;
        if (bus[g].o_b_v && bus[g].i_b_r) begin
          if (bus[g].o_b_preset == '0) zv <= 1'b1;
          else begin
            busy <= 1'b1;
            cnt  <= bus[g].o_b_preset;
          end
        end else if (busy) begin
          if (cnt == 1) begin
            zv   <= 1'b1;
            busy <= 1'b0;
          end else cnt <= cnt - 1'b1;
        end
      end
    end
  end

  logic a_r_s, b_v_s, b_r_s, c_v_s, c_r_s, z_v_s, last_s;
  logic [N-1:0] preset_s;
  logic [M-1:0] idx_s;
  assign a_r_s    = obs_a_r[sel];
  assign b_v_s    = obs_b_v[sel];
  assign b_r_s    = obs_b_r[sel];
  assign c_v_s    = obs_c_v[sel];
  assign c_r_s    = obs_c_r[sel];
  assign z_v_s    = obs_z_v[sel];
  assign last_s   = obs_z_last[sel];
  assign preset_s = obs_preset[sel];
  assign idx_s    = obs_idx[sel];

  typedef struct {
    int cyc;
    int v1;
    int v2;
  } rec_t;

  rec_t pre_q[$];
  rec_t ev_q[$];
  int   exp_q[$];
  int   cmd_q[$];
  int   bv_seen = 0;
  int   zv_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every handshake of the selected instance with the edge it fires on.
  always @(negedge clk) begin
    if (!reset) begin
      if (a_v && a_r_s) cmd_q.push_back(cyc + 1);
      if (b_v_s) bv_seen <= bv_seen + 1;
      if (z_v_s) zv_seen <= zv_seen + 1;
      if (b_v_s && b_r_s) pre_q.push_back('{cyc + 1, int'(preset_s), 0});
      if (c_v_s && c_r_s) exp_q.push_back(cyc + 1);
      if (z_v_s && z_r) ev_q.push_back('{cyc + 1, int'(idx_s), int'(last_s)});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_point();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    pre_q.delete();
    ev_q.delete();
    exp_q.delete();
    cmd_q.delete();
    bv_seen = 0;
    zv_seen = 0;
  endtask

  task automatic do_reset();
    drive_point();
    reset  = 1'b1;
    a_v    = 1'b0;
    b_r_en = 1'b1;
    z_r    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    reset = 1'b0;
  endtask

  task automatic send_cmd(input int iv, input int r);
    int n;
    n = 0;
    drive_point();
    a_v   = 1'b1;
    a_int = N'(iv);
    a_rep = M'(r);
    tick();
    while (!a_r_s && n < 50) begin
      tick();
      n++;
    end
    n_checks++;
    if (a_r_s !== 1'b1) $display("FAIL cmd_accept qz=%0d: o_a_r=%b required 1", sel, a_r_s);
    else n_pass++;
    drive_point();
    a_v = 1'b0;
  endtask

  task automatic wait_ev(input int n, input int budget);
    int k;
    k = 0;
    while (ev_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    n_checks++;
    if (ev_q.size() !== n) $display("FAIL event_count qz=%0d: got %0d required %0d", sel, ev_q.size(), n);
    else n_pass++;
  endtask

  task automatic test_reset();
    drive_point();
    reset = 1'b1;
    a_v   = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({a_r_s, b_v_s, c_r_s, z_v_s} !== 4'b0000)
      $display("FAIL reset_held qz=%0d: {a_r,b_v,c_r,z_v}=%b required 0000", sel, {a_r_s, b_v_s, c_r_s, z_v_s});
    else n_pass++;
    drive_point();
    clear_logs();
    reset = 1'b0;
    tick();
    n_checks++;
    if ({a_r_s, b_v_s, c_r_s, z_v_s} !== 4'b1000)
      $display("FAIL reset_hs qz=%0d: {a_r,b_v,c_r,z_v}=%b required 1000", sel, {a_r_s, b_v_s, c_r_s, z_v_s});
    else n_pass++;
    n_checks++;
    if ({preset_s, idx_s, last_s} !== '0)
      $display("FAIL reset_data qz=%0d: preset=%0d index=%0d last=%b required 0/0/0", sel, preset_s, idx_s, last_s);
    else n_pass++;
  endtask

  task automatic test_basic();
    int t;
    do_reset();
    send_cmd(3, 2);
    wait_ev(2, 60);
    t = (cmd_q.size() > 0) ? cmd_q[0] : -1000;
    n_checks++;
    if (pre_q.size() !== 2) $display("FAIL basic_presets qz=%0d: got %0d required 2", sel, pre_q.size());
    else n_pass++;
    if (pre_q.size() == 2 && ev_q.size() == 2) begin
      n_checks++;
      if (pre_q[0].cyc !== t + 1 || pre_q[0].v1 !== 3)
        $display("FAIL basic_preset0 qz=%0d: edge=%0d val=%0d required %0d/3", sel, pre_q[0].cyc - t, pre_q[0].v1, 1);
      else n_pass++;
      n_checks++;
      if (pre_q[1].cyc !== t + 7 || pre_q[1].v1 !== 3)
        $display("FAIL basic_preset1 qz=%0d: edge=%0d val=%0d required 7/3", sel, pre_q[1].cyc - t, pre_q[1].v1);
      else n_pass++;
      n_checks++;
      if (ev_q[0].cyc !== t + 6 + sel || ev_q[0].v1 !== 0 || ev_q[0].v2 !== 0)
        $display("FAIL basic_ev0 qz=%0d: edge=%0d idx=%0d last=%0d required %0d/0/0", sel, ev_q[0].cyc - t, ev_q[0].v1, ev_q[0].v2, 6 + sel);
      else n_pass++;
      n_checks++;
      if (ev_q[1].cyc !== t + 12 + sel || ev_q[1].v1 !== 1 || ev_q[1].v2 !== 1)
        $display("FAIL basic_ev1 qz=%0d: edge=%0d idx=%0d last=%0d required %0d/1/1", sel, ev_q[1].cyc - t, ev_q[1].v1, ev_q[1].v2, 12 + sel);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (a_r_s !== 1'b1) $display("FAIL basic_ready_back qz=%0d: o_a_r=%b required 1", sel, a_r_s);
    else n_pass++;
  endtask

  task automatic test_repeat_zero();
    int ar_low;
    ar_low = 0;
    do_reset();
    send_cmd(5, 0);
    repeat (10) begin
      tick();
      if (!a_r_s) ar_low++;
    end
    n_checks++;
    if (cmd_q.size() !== 1) $display("FAIL r0_consumed qz=%0d: got %0d required 1", sel, cmd_q.size());
    else n_pass++;
    n_checks++;
    if (ar_low !== 0) $display("FAIL r0_ready qz=%0d: o_a_r low %0d cycles required 0", sel, ar_low);
    else n_pass++;
    n_checks++;
    if (bv_seen !== 0 || zv_seen !== 0)
      $display("FAIL r0_quiet qz=%0d: b_v cycles=%0d z_v cycles=%0d required 0/0", sel, bv_seen, zv_seen);
    else n_pass++;
  endtask

  task automatic test_zero_interval();
    int t;
    do_reset();
    send_cmd(0, 1);
    wait_ev(1, 30);
    t = (cmd_q.size() > 0) ? cmd_q[0] : -1000;
    if (ev_q.size() == 1 && pre_q.size() == 1 && exp_q.size() == 1) begin
      n_checks++;
      if (pre_q[0].cyc !== t + 1 || pre_q[0].v1 !== 0)
        $display("FAIL zi_preset qz=%0d: edge=%0d val=%0d required 1/0", sel, pre_q[0].cyc - t, pre_q[0].v1);
      else n_pass++;
      n_checks++;
      if (exp_q[0] !== t + 2) $display("FAIL zi_expiry qz=%0d: edge=%0d required 2", sel, exp_q[0] - t);
      else n_pass++;
      n_checks++;
      if (ev_q[0].cyc !== t + 3 + sel || ev_q[0].v1 !== 0 || ev_q[0].v2 !== 1)
        $display("FAIL zi_event qz=%0d: edge=%0d idx=%0d last=%0d required %0d/0/1", sel, ev_q[0].cyc - t, ev_q[0].v1, ev_q[0].v2, 3 + sel);
      else n_pass++;
    end else begin
      n_checks++;
      $display("FAIL zi_logs qz=%0d: presets=%0d expiries=%0d required 1/1", sel, pre_q.size(), exp_q.size());
    end
  endtask

  task automatic test_z_backpressure();
    int k;
    do_reset();
    z_r = 1'b0;
    send_cmd(1, 2);
    k = 0;
    while (!z_v_s && k < 30) begin
      tick();
      k++;
    end
    repeat (5) begin
      tick();
      n_checks++;
      if ({z_v_s, idx_s, last_s} !== {1'b1, 4'd0, 1'b0})
        $display("FAIL zbp_hold qz=%0d: z_v=%b idx=%0d last=%b required 1/0/0", sel, z_v_s, idx_s, last_s);
      else n_pass++;
    end
    n_checks++;
    if (pre_q.size() !== (sel == 0 ? 1 : 2))
      $display("FAIL zbp_presets qz=%0d: got %0d required %0d", sel, pre_q.size(), sel == 0 ? 1 : 2);
    else n_pass++;
    drive_point();
    z_r = 1'b1;
    wait_ev(2, 40);
    if (ev_q.size() == 2) begin
      n_checks++;
      if (ev_q[0].v1 !== 0 || ev_q[0].v2 !== 0 || ev_q[1].v1 !== 1 || ev_q[1].v2 !== 1)
        $display("FAIL zbp_events qz=%0d: %0d/%0d %0d/%0d required 0/0 1/1", sel, ev_q[0].v1, ev_q[0].v2, ev_q[1].v1, ev_q[1].v2);
      else n_pass++;
    end
  endtask

  task automatic test_b_backpressure();
    int k;
    do_reset();
    b_r_en = 1'b0;
    send_cmd(2, 1);
    k = 0;
    while (!b_v_s && k < 20) begin
      tick();
      k++;
    end
    repeat (4) begin
      tick();
      n_checks++;
      if ({b_v_s, preset_s, c_r_s} !== {1'b1, 8'd2, 1'b0})
        $display("FAIL bbp_hold qz=%0d: b_v=%b preset=%0d c_r=%b required 1/2/0", sel, b_v_s, preset_s, c_r_s);
      else n_pass++;
    end
    drive_point();
    b_r_en = 1'b1;
    wait_ev(1, 30);
    if (ev_q.size() == 1 && pre_q.size() == 1) begin
      n_checks++;
      if (pre_q[0].v1 !== 2 || ev_q[0].v1 !== 0 || ev_q[0].v2 !== 1)
        $display("FAIL bbp_result qz=%0d: preset=%0d idx=%0d last=%0d required 2/0/1", sel, pre_q[0].v1, ev_q[0].v1, ev_q[0].v2);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int k;
    int t;
    do_reset();
    send_cmd(5, 3);
    k = 0;
    while (!c_r_s && k < 20) begin
      tick();
      k++;
    end
    n_checks++;
    if (c_r_s !== 1'b1) $display("FAIL rm_in_wait qz=%0d: o_c_r=%b required 1", sel, c_r_s);
    else n_pass++;
    drive_point();
    reset = 1'b1;
    drive_point();
    clear_logs();
    reset = 1'b0;
    #1;
    n_checks++;
    if ({a_r_s, b_v_s, c_r_s, z_v_s} !== 4'b1000)
      $display("FAIL rm_idle qz=%0d: {a_r,b_v,c_r,z_v}=%b required 1000", sel, {a_r_s, b_v_s, c_r_s, z_v_s});
    else n_pass++;
    send_cmd(2, 1);
    wait_ev(1, 30);
    t = (cmd_q.size() > 0) ? cmd_q[0] : -1000;
    if (ev_q.size() == 1 && pre_q.size() == 1) begin
      n_checks++;
      if (pre_q[0].cyc !== t + 1 || pre_q[0].v1 !== 2)
        $display("FAIL rm_preset qz=%0d: edge=%0d val=%0d required 1/2", sel, pre_q[0].cyc - t, pre_q[0].v1);
      else n_pass++;
      n_checks++;
      if (ev_q[0].cyc !== t + 5 + sel || ev_q[0].v1 !== 0 || ev_q[0].v2 !== 1)
        $display("FAIL rm_event qz=%0d: edge=%0d idx=%0d last=%0d required %0d/0/1", sel, ev_q[0].cyc - t, ev_q[0].v1, ev_q[0].v2, 5 + sel);
      else n_pass++;
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      sel = s;
      test_reset();
      test_basic();
      test_repeat_zero();
      test_zero_interval();
      test_z_backpressure();
      test_b_backpressure();
      test_reset_mid();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
